// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage with a variable-latency memory handshake.
// Optional macro PC_MISALIGN_TRAP_EN: redirect misaligned targets to MTVEC instead of truncating them.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_FETCH | request outstanding at PC; waiting for IMEM_ACK
// S_HOLD  | INSTR valid and held; waiting for PC_WRITE from control

module pc_fetch_unit #(
  parameter logic [31:0] RESET_VEC     = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  PC_SOURCE,
  input  logic [31:0] JALR,
  input  logic [31:0] BRANCH,
  input  logic [31:0] JUMP,
  input  logic [31:0] MTVEC,
  input  logic [31:0] MEPC,
  input  logic        PC_WRITE,
  input  logic [31:0] IMEM_DOUT,
  input  logic        IMEM_ACK,
  output logic        IMEM_RD,
  output logic [31:0] IMEM_ADDR,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic [31:0] INSTR,
  output logic        INSTR_VALID,
  output logic        FETCH_ERR,
  output logic        MISALIGN
);

  localparam int                CNT_W    = $clog2(FETCH_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);
  localparam logic [31:0]       NOP      = 32'h0000_0013;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       pc_plus4;
  logic [31:0]       next_pc;

  assign pc_plus4 = pc_q + 32'd4;

  // Reserved selects 6 and 7 fall through to sequential flow.
  always_comb begin
    next_pc = pc_plus4;
    case (PC_SOURCE)
      3'd1:    next_pc = JALR;
      3'd2:    next_pc = BRANCH;
      3'd3:    next_pc = JUMP;
      3'd4:    next_pc = MTVEC;
      3'd5:    next_pc = MEPC;
      default: next_pc = pc_plus4;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef PC_MISALIGN_TRAP_EN
    mis_d   = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        if (IMEM_ACK) begin
          instr_d = IMEM_DOUT;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          // Flag the stall but keep the request up; the fetch retries forever.
          err_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (PC_WRITE) begin
          valid_d = 1'b0;
          state_d = S_FETCH;
`ifdef PC_MISALIGN_TRAP_EN
          if (next_pc[1:0] != 2'b00) begin
            pc_d  = MTVEC;
            mis_d = 1'b1;
          end else begin
            pc_d = next_pc;
          end
`else
          pc_d = next_pc & ~32'h3;
`endif
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_VEC;
      instr_q <= NOP;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) mis_q <= 1'b0;
    else     mis_q <= mis_d;
  end
  assign MISALIGN = mis_q;
`else
  assign MISALIGN = 1'b0;
`endif

  assign IMEM_RD     = (state_q == S_FETCH) & ~RST;
  assign IMEM_ADDR   = pc_q;
  assign PC          = pc_q;
  assign PC_PLUS4    = pc_plus4;
  assign INSTR       = instr_q;
  assign INSTR_VALID = valid_q;
  assign FETCH_ERR   = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed vector table, corner sequences and a
// randomized run against a behavioural model. Honours PC_MISALIGN_TRAP_EN if defined.

module tb_pc_fetch_unit;

  localparam int TO = 8;

  logic        clk, rst;
  logic [2:0]  pc_source;
  logic [31:0] jalr, branch, jump, mtvec, mepc;
  logic        pc_write;
  logic [31:0] imem_dout;
  logic        imem_ack;
  logic        imem_rd;
  logic [31:0] imem_addr, pc, pc_plus4, instr;
  logic        instr_valid, fetch_err, misalign;

  int errors = 0;
  int checks = 0;

  pc_fetch_unit #(.RESET_VEC(32'h0), .FETCH_TIMEOUT(TO)) dut (
    .CLK(clk), .RST(rst), .PC_SOURCE(pc_source),
    .JALR(jalr), .BRANCH(branch), .JUMP(jump), .MTVEC(mtvec), .MEPC(mepc),
    .PC_WRITE(pc_write), .IMEM_DOUT(imem_dout), .IMEM_ACK(imem_ack),
    .IMEM_RD(imem_rd), .IMEM_ADDR(imem_addr), .PC(pc), .PC_PLUS4(pc_plus4),
    .INSTR(instr), .INSTR_VALID(instr_valid), .FETCH_ERR(fetch_err), .MISALIGN(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ack, input logic [31:0] dout, input logic pcw,
                       input logic [2:0] src, input logic [31:0] tgt);
    imem_ack  = ack;
    imem_dout = dout;
    pc_write  = pcw;
    pc_source = src;
    jalr      = tgt;
    branch    = tgt;
    jump      = tgt;
    mepc      = tgt;
  endtask

  typedef struct {
    logic        ack;
    logic [31:0] dout;
    logic        pcw;
    logic [2:0]  src;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_instr;
    logic        e_rd;
  } vec_t;

  vec_t vecs[19];

  // Behavioural reference model state
  logic [31:0] m_pc, m_instr;
  logic        m_valid, m_err, m_fetching, m_mis;
  int          m_nack;

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h13; m_valid = 0; m_err = 0;
    m_fetching = 1; m_mis = 0; m_nack = 0;
  endtask

  task automatic model_step();
    logic [31:0] cand[8];
    logic [31:0] t;
    m_mis = 0;
    if (m_fetching) begin
      if (imem_ack) begin
        m_instr = imem_dout; m_valid = 1; m_fetching = 0; m_nack = 0;
      end else begin
        m_nack++;
        if (m_nack == TO) begin
          m_err = 1; m_nack = 0;
        end
      end
    end else if (pc_write) begin
      cand = '{m_pc + 32'd4, jalr, branch, jump, mtvec, mepc, m_pc + 32'd4, m_pc + 32'd4};
      t = cand[pc_source];
      m_valid = 0; m_fetching = 1;
`ifdef PC_MISALIGN_TRAP_EN
      if (t % 4 != 0) begin
        m_pc = mtvec; m_mis = 1;
      end else m_pc = t;
`else
      m_pc = t - (t % 4);
`endif
    end
  endtask

  initial begin
    logic [31:0] exp_mis_pc;
    int ack_pct;

    vecs[0]  = '{1, 32'h0050_0093, 0, 0, 32'h0,   32'h0,   1, 32'h0050_0093, 0};
    vecs[1]  = '{0, 32'h0,         1, 0, 32'h0,   32'h4,   0, 32'h0050_0093, 1};
    vecs[2]  = '{1, 32'h00A0_0113, 0, 0, 32'h0,   32'h4,   1, 32'h00A0_0113, 0};
    vecs[3]  = '{0, 32'h0,         1, 2, 32'h10,  32'h10,  0, 32'h00A0_0113, 1};
    vecs[4]  = '{1, 32'h1111_1111, 0, 0, 32'h0,   32'h10,  1, 32'h1111_1111, 0};
    vecs[5]  = '{0, 32'h0,         1, 3, 32'h80,  32'h80,  0, 32'h1111_1111, 1};
    vecs[6]  = '{1, 32'h2222_2222, 0, 0, 32'h0,   32'h80,  1, 32'h2222_2222, 0};
    vecs[7]  = '{0, 32'h0,         1, 4, 32'h0,   32'h200, 0, 32'h2222_2222, 1};
    vecs[8]  = '{1, 32'h3333_3333, 0, 0, 32'h0,   32'h200, 1, 32'h3333_3333, 0};
    vecs[9]  = '{0, 32'h0,         1, 5, 32'h24,  32'h24,  0, 32'h3333_3333, 1};
    vecs[10] = '{1, 32'h4444_4444, 0, 0, 32'h0,   32'h24,  1, 32'h4444_4444, 0};
    vecs[11] = '{0, 32'h0,         1, 7, 32'h900, 32'h28,  0, 32'h4444_4444, 1};
    vecs[12] = '{1, 32'h5555_5555, 0, 0, 32'h0,   32'h28,  1, 32'h5555_5555, 0};
    vecs[13] = '{0, 32'h0,         1, 6, 32'h900, 32'h2C,  0, 32'h5555_5555, 1};
    vecs[14] = '{0, 32'h0,         1, 3, 32'h400, 32'h2C,  0, 32'h5555_5555, 1};
    vecs[15] = '{1, 32'h6666_6666, 0, 0, 32'h0,   32'h2C,  1, 32'h6666_6666, 0};
    vecs[16] = '{1, 32'h7777_7777, 0, 0, 32'h0,   32'h2C,  1, 32'h6666_6666, 0};
    vecs[17] = '{0, 32'h0,         1, 1, 32'h100, 32'h100, 0, 32'h6666_6666, 1};
    vecs[18] = '{1, 32'h8888_8888, 0, 0, 32'h0,   32'h100, 1, 32'h8888_8888, 0};

    rst = 1'b1;
    mtvec = 32'h200;
    drive(0, 32'h0, 0, 0, 32'h0);

    // Reset held for three cycles
    repeat (3) tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h13);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_rd", {31'b0, imem_rd}, 32'h0);
    chk("rst_err", {31'b0, fetch_err}, 32'h0);
    chk("rst_mis", {31'b0, misalign}, 32'h0);
    rst = 1'b0;
    #1;
    chk("rel_rd", {31'b0, imem_rd}, 32'h1);
    chk("rel_addr", imem_addr, 32'h0);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].ack, vecs[i].dout, vecs[i].pcw, vecs[i].src, vecs[i].tgt);
      tick();
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_pc);
      chk($sformatf("vec%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("vec%0d_instr", i), instr, vecs[i].e_instr);
      chk($sformatf("vec%0d_rd", i), {31'b0, imem_rd}, {31'b0, vecs[i].e_rd});
    end

    // Wait states with a stray PC_WRITE during FETCH
    drive(0, 32'h0, 1, 0, 32'h0);
    tick();
    chk("ws_pc", pc, 32'h104);
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'hDEAD_BEEF, (i == 1), 3, 32'h500);
      tick();
      chk($sformatf("ws%0d_addr", i), imem_addr, 32'h104);
      chk($sformatf("ws%0d_valid", i), {31'b0, instr_valid}, 32'h0);
      chk($sformatf("ws%0d_rd", i), {31'b0, imem_rd}, 32'h1);
    end
    drive(1, 32'hAAAA_AAAA, 0, 0, 32'h0);
    tick();
    chk("ws_done_valid", {31'b0, instr_valid}, 32'h1);
    chk("ws_done_instr", instr, 32'hAAAA_AAAA);

    // PC+4 wraps at the top of the address space
    drive(0, 32'h0, 1, 3, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    drive(1, 32'h1234_5678, 0, 0, 32'h0);
    tick();
    drive(0, 32'h0, 1, 0, 32'h0);
    tick();
    chk("wrap_next_pc", pc, 32'h0);
    drive(1, 32'h0000_0013, 0, 0, 32'h0);
    tick();

    // Misaligned JALR target
`ifdef PC_MISALIGN_TRAP_EN
    exp_mis_pc = 32'h200;
`else
    exp_mis_pc = 32'h100;
`endif
    drive(0, 32'h0, 1, 1, 32'h102);
    tick();
    chk("mis_pc", pc, exp_mis_pc);
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_pulse", {31'b0, misalign}, 32'h1);
`else
    chk("mis_pulse", {31'b0, misalign}, 32'h0);
`endif
    drive(0, 32'h0, 0, 0, 32'h0);
    tick();
    chk("mis_pulse_end", {31'b0, misalign}, 32'h0);
    chk("mis_pc_hold", pc, exp_mis_pc);
    drive(1, 32'hBBBB_BBBB, 0, 0, 32'h0);
    tick();

    // Fetch timeout after TO cycles without ACK
    drive(0, 32'h0, 1, 0, 32'h0);
    tick();
    drive(0, 32'h0, 0, 0, 32'h0);
    repeat (TO - 1) tick();
    chk("to_not_yet", {31'b0, fetch_err}, 32'h0);
    tick();
    chk("to_err", {31'b0, fetch_err}, 32'h1);
    chk("to_rd", {31'b0, imem_rd}, 32'h1);
    drive(1, 32'hCCCC_CCCC, 0, 0, 32'h0);
    tick();
    chk("to_late_valid", {31'b0, instr_valid}, 32'h1);
    chk("to_late_instr", instr, 32'hCCCC_CCCC);
    drive(0, 32'h0, 1, 0, 32'h0);
    tick();
    drive(1, 32'hDDDD_DDDD, 0, 0, 32'h0);
    tick();
    chk("to_sticky", {31'b0, fetch_err}, 32'h1);

    // Reset mid-fetch, ACK in the release cycle answers RESET_VEC
    drive(0, 32'h0, 1, 0, 32'h0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_rd", {31'b0, imem_rd}, 32'h0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_err", {31'b0, fetch_err}, 32'h0);
    tick();
    rst = 1'b0;
    drive(1, 32'h9999_9999, 0, 0, 32'h0);
    tick();
    chk("mid_rst_valid", {31'b0, instr_valid}, 32'h1);
    chk("mid_rst_instr", instr, 32'h9999_9999);
    chk("mid_rst_pc2", pc, 32'h0);

    // Randomized run against the behavioural model
    rst = 1'b1;
    drive(0, 32'h0, 0, 0, 32'h0);
    tick();
    rst = 1'b0;
    model_reset();
    ack_pct = 60;
    for (int c = 0; c < 500; c++) begin
      if (c % 50 == 0) ack_pct = ($urandom_range(0, 1) == 0) ? 8 : 65;
      imem_ack  = ($urandom_range(0, 99) < ack_pct);
      imem_dout = $urandom;
      pc_write  = ($urandom_range(0, 1) == 1);
      pc_source = 3'($urandom_range(0, 7));
      jalr      = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      branch    = $urandom & 32'hFFFF_FFFC;
      jump      = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      mepc      = $urandom & 32'hFFFF_FFFC;
      mtvec     = $urandom & 32'hFFFF_FFFC;
      model_step();
      tick();
      chk("rnd_pc", pc, m_pc);
      chk("rnd_addr", imem_addr, m_pc);
      chk("rnd_plus4", pc_plus4, m_pc + 32'd4);
      chk("rnd_instr", instr, m_instr);
      chk("rnd_valid", {31'b0, instr_valid}, {31'b0, m_valid});
      chk("rnd_rd", {31'b0, imem_rd}, {31'b0, m_fetching});
      chk("rnd_err", {31'b0, fetch_err}, {31'b0, m_err});
      chk("rnd_mis", {31'b0, misalign}, {31'b0, m_mis});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
